// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the pipelined CPU: field widths, opcode list and
// fetch FSM encoding, used by both the fetch stage and the instruction ROM.
package cpu_isa_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 9;
    localparam int OP_W   = 5;
    localparam int CNT_W  = 16;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 5'b00000,
        OP_HALT = 5'b11010,
        OP_TBD  = 5'b11011
    } opcode_e;

    typedef enum logic [1:0] {
        S_START,
        S_RUN,
        S_HALT
    } fetch_state_e;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[INST_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: ROM address/data, hazard and redirect controls, IF/ID outputs.
// master = the fetch stage, slave = ROM, hazard unit, EX and decode.
interface instruction_fetch_stage_if;
    import cpu_isa_pkg::*;

    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] rom_inst;
    logic              stall;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic [INST_W-1:0] id_inst;
    logic [PC_W-1:0]   id_pc;
    logic              id_valid;
    logic              halted;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        output pc, id_inst, id_pc, id_valid, halted, fetch_count,
        input  rom_inst, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  pc, id_inst, id_pc, id_valid, halted, fetch_count,
        output rom_inst, stall, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register with flush > hold > load priority; usable for
// IF/ID and ID/EX alike.
module if_id_reg #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              hold,
    input  logic              load,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic              valid
);

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: payload is reset too, not just valid, so downstream sees
            // a defined all-zero instruction rather than X after reset.
            inst  <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (hold) begin
            valid <= valid;
        end else if (load) begin
            inst  <= in_inst;
            pc    <= in_pc;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, feeds the combinational ROM, registers instructions
// into IF/ID, and handles stall, EX redirect and halt.
module instruction_fetch_stage
    import cpu_isa_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [OP_W-1:0] HALT_OP  = OP_HALT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_fetch_stage_if.master  bus
);

    fetch_state_e     state_q, state_next;
    logic [PC_W-1:0]  pc_q, pc_next;
    logic             halted_q, halted_next;
    logic [CNT_W-1:0] count_q;
    logic             load, flush, hold, count_inc;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would infer a latch.
        state_next  = state_q;
        pc_next     = pc_q;
        halted_next = halted_q;
        load        = 1'b0;
        flush       = 1'b0;
        hold        = 1'b0;
        count_inc   = 1'b0;

        unique case (state_q)
            S_START: begin
                pc_next    = RESET_PC;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (bus.redirect_valid) begin
                    pc_next = bus.redirect_pc;
                    flush   = 1'b1;
                end else if (bus.stall) begin
                    hold = 1'b1;
                end else begin
                    load      = 1'b1;
                    count_inc = 1'b1;
                    // Halt is delivered to ID but the PC parks on it.
                    if (opcode_of(bus.rom_inst) == HALT_OP)
                        state_next = S_HALT;
                    else
                        pc_next = pc_q + PC_W'(1);
                end
            end
            S_HALT: begin
                flush = 1'b1;
                // An older taken branch can cancel a speculatively fetched halt.
                if (bus.redirect_valid) begin
                    pc_next     = bus.redirect_pc;
                    halted_next = 1'b0;
                    state_next  = S_RUN;
                end else begin
                    halted_next = 1'b1;
                end
            end
            default: state_next = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_START;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_next;
            pc_q     <= pc_next;
            halted_q <= halted_next;
            if (count_inc && count_q != '1)
                count_q <= count_q + CNT_W'(1);
        end
    end

    if_id_reg #(
        .DATA_W (INST_W),
        .ADDR_W (PC_W)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .hold    (hold),
        .load    (load),
        .in_inst (bus.rom_inst),
        .in_pc   (pc_q),
        .inst    (bus.id_inst),
        .pc      (bus.id_pc),
        .valid   (bus.id_valid)
    );

    assign bus.pc          = pc_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the pipelined CPU. Owns the program counter and drives it to the combinational instruction ROM (16-bit pc in, 9-bit {opcode[4:0], operand[3:0]} out, same cycle).
- Registers each returned instruction into the IF/ID pipeline register for decode.
- Handles stall from the hazard unit, redirect (taken branch/jump) from EX, and halt detection.

Parameters:
- PC_W, 16, program counter width
- INST_W, 9, instruction width
- OP_W, 5, opcode field width (instruction[8:4])
- RESET_PC, 0, first fetch address after reset
- HALT_OP, 5'b11010, opcode that stops fetch

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- pc  out  PC_W  fetch address to instruction ROM
- rom_inst  in  INST_W  instruction returned by ROM for pc (same cycle)
- stall  in  1  hazard unit: hold pc and IF/ID contents
- redirect_valid  in  1  EX: branch/jump taken this cycle
- redirect_pc  in  PC_W  absolute target for redirect
- id_inst  out  INST_W  IF/ID instruction
- id_pc  out  PC_W  address of id_inst
- id_valid  out  1  id_inst is a real instruction (0 = bubble)
- halted  out  1  fetch stopped on HALT_OP
- fetch_count  out  16  instructions delivered to ID, saturating

Behaviour:
- Reset is synchronous and active low: on a clk edge with rst_n=0, all state is initialised and the FSM enters S_START. Reset is honoured mid-operation, including mid-stall and in S_HALT.
- Reset values: pc=RESET_PC, id_inst=0, id_pc=0, id_valid=0, halted=0, fetch_count=0.
- FSM states:
  - S_START: one cycle after reset; pc=RESET_PC, no capture, id_valid stays 0; next state S_RUN unconditionally.
  - S_RUN: normal fetch.
  - S_HALT: pc frozen, id_valid=0, halted=1.
- Per-edge priority in S_RUN: reset > redirect > stall > normal.
- Redirect (redirect_valid=1):
  - pc <= redirect_pc; id_valid <= 0 (the wrong-path instruction is flushed).
  - fetch_count unchanged.
  - Wins over a simultaneous stall and over a HALT_OP currently on rom_inst.
- Stall (stall=1, no redirect): pc, id_inst, id_pc, id_valid and fetch_count all hold.
- Normal:
  - id_inst <= rom_inst; id_pc <= pc; id_valid <= 1.
  - fetch_count <= fetch_count+1, saturating at 16'hFFFF.
  - pc <= pc+1, wrapping 16'hFFFF -> 16'h0000.
- Halt: a normal capture with rom_inst[8:4]==HALT_OP delivers the halt instruction to ID (id_valid=1), then:
  - pc holds at the halt address; state -> S_HALT.
  - halted=1 from the following cycle.
  - On the next edge id_valid <= 0.
- In S_HALT:
  - stall is ignored.
  - redirect_valid=1 returns the FSM to S_RUN with pc <= redirect_pc and halted <= 0, because an older branch in EX can cancel a speculatively fetched halt. id_valid stays 0 that cycle.
- Latency: instruction at address A appears on id_inst exactly one edge after pc==A with no stall and no redirect. Throughput is one instruction per cycle.
- The stage decodes no opcode other than HALT_OP; operand bits pass through unchanged.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - the 5-bit opcode constants (add=00000 … halt=11010, toBeDefined=11011);
  - OP_W, INST_W, PC_W;
  - the fetch FSM state encoding (S_START, S_RUN, S_HALT).
- The ROM already uses the same opcode list; moving the constants into cpu_isa_pkg gives both blocks a single source.
- One natural sub-module: if_id_reg. It is the IF/ID pipeline register with hold, flush and load controls, and it is reusable for the ID/EX register.
- The PC, FSM and counter stay in the top module.

Test Plan:
- Reset then run, ROM returns 9'h0B0 at pc 0 and 9'h031 at pc 1, no stall: S_START for one cycle with id_valid=0; then id_inst=0x0B0, id_pc=0; next cycle id_inst=0x031, id_pc=1; fetch_count=2.
- stall=1 for 3 cycles while pc=5: pc stays 5, id_inst/id_pc frozen, fetch_count unchanged. After release, id_pc=5 on the next edge.
- redirect_valid=1, redirect_pc=74 with stall=1 at pc=60: next edge gives pc=74 and id_valid=0; the following edge gives id_pc=74, id_valid=1.
- ROM returns 9'h1A0 (halt) at pc 81: id_inst=0x1A0 and id_valid=1 for one cycle. Then halted=1, pc stays 81, id_valid=0 indefinitely, and stall toggling has no effect.
- In S_HALT, assert redirect_valid with redirect_pc=16: halted=0, pc=16, and fetch resumes. A separate case drives 9'h1A0 at the same edge as redirect_valid: the halt is discarded and halted never rises.
- Preload pc=16'hFFFF via redirect, then run: pc wraps to 0 and id_pc sequence is FFFF, 0000. Separately, rst_n=0 asserted during a stall restores pc=0, fetch_count=0, id_valid=0 on that edge.
